// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed, checksummed program image over a
// byte stream and writes it word by word into instruction memory. The
// processor is held in reset until the image has loaded with a good checksum.
module prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic        cpu_rst,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [7:0]  len_hi_q, len_hi_d;
    logic [15:0] len_q, len_d;
    logic [15:0] widx_q, widx_d;
    logic [1:0]  bidx_q, bidx_d;
    logic [31:0] asm_q, asm_d;
    logic [7:0]  csum_q, csum_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] din_q, din_d;

    logic        rx_ready_q, mem_en_q, cpu_rst_q, done_q, err_q;
    logic [3:0]  mem_we_q;

    logic        accept;
    logic [7:0]  sum_next;
    logic [15:0] n_rx;
    logic [31:0] word_next;

    assign accept    = rx_valid && rx_ready_q;
    assign sum_next  = csum_q + rx_data;
    assign n_rx      = {len_hi_q, rx_data};
    assign word_next = {asm_q[23:0], rx_data};

    assign rx_ready = rx_ready_q;
    assign mem_addr = addr_q;
    assign mem_din  = din_q;
    assign mem_en   = mem_en_q;
    assign mem_we   = mem_we_q;
    assign cpu_rst  = cpu_rst_q;
    assign done     = done_q;
    assign err      = err_q;

    // Next-state and datapath updates for the load sequence
    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        len_d    = len_q;
        widx_d   = widx_q;
        bidx_d   = bidx_q;
        asm_d    = asm_q;
        csum_d   = csum_q;
        addr_d   = addr_q;
        din_d    = din_q;
        case (state_q)
            S_IDLE: state_d = S_LEN_HI;
            S_LEN_HI: if (accept) begin
                len_hi_d = rx_data;
                csum_d   = sum_next;
                state_d  = S_LEN_LO;
            end
            S_LEN_LO: if (accept) begin
                len_d  = n_rx;
                csum_d = sum_next;
                widx_d = '0;
                bidx_d = '0;
                if (n_rx == 16'h0000)        state_d = S_CSUM;
                else if ({1'b0, n_rx} > MAX_N) state_d = S_ERR;
                else                         state_d = S_DATA;
            end
            S_DATA: if (accept) begin
                asm_d  = word_next;
                csum_d = sum_next;
                bidx_d = bidx_q + 2'd1;
                if (bidx_q == 2'd3) begin
                    // Memory port values are latched here so they are already
                    // stable for the whole WRITE cycle.
                    addr_d  = BASE_ADDR + {16'h0000, widx_q};
                    din_d   = word_next;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                widx_d  = widx_q + 16'd1;
                state_d = (widx_q + 16'd1 == len_q) ? S_CSUM : S_DATA;
            end
            S_CSUM: if (accept) begin
                csum_d  = sum_next;
                state_d = (sum_next == 8'h00) ? S_DONE : S_ERR;
            end
            S_DONE, S_ERR: if (start) begin
                csum_d  = '0;
                widx_d  = '0;
                bidx_d  = '0;
                asm_d   = '0;
                state_d = S_LEN_HI;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; outputs are decoded from the next state so they are registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_hi_q   <= '0;
            len_q      <= '0;
            widx_q     <= '0;
            bidx_q     <= '0;
            asm_q      <= '0;
            csum_q     <= '0;
            addr_q     <= BASE_ADDR;
            din_q      <= '0;
            rx_ready_q <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 4'h0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_hi_q   <= len_hi_d;
            len_q      <= len_d;
            widx_q     <= widx_d;
            bidx_q     <= bidx_d;
            asm_q      <= asm_d;
            csum_q     <= csum_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            rx_ready_q <= state_d inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM};
            mem_en_q   <= (state_d == S_WRITE);
            mem_we_q   <= (state_d == S_WRITE) ? 4'hF : 4'h0;
            cpu_rst_q  <= (state_d != S_DONE);
            done_q     <= (state_d == S_DONE);
            err_q      <= (state_d == S_ERR);
        end
    end

endmodule
